// File: rtl/simon_pkg.sv
// Shared constants, FSM encoding and rotate helper for the Simon 32/64 encryption engine.
package simon_pkg;

  localparam int WORD_W    = 16;
  localparam int ROUNDS    = 32;
  localparam int KEY_BUS_W = ROUNDS * WORD_W;
  localparam int RND_W     = $clog2(ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Rotate left by a constant amount, modulo the word width.
  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int unsigned s);
    return (v << s) | (v >> (WORD_W - s));
  endfunction

endpackage

// File: rtl/simon_round.sv
// One combinational Simon round: x' = y ^ f(x) ^ k, y' = x.
module simon_round
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] k,
  output logic [WORD_W-1:0] x_next,
  output logic [WORD_W-1:0] y_next
);

  logic [WORD_W-1:0] f_s;

  assign f_s    = (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
  assign x_next = y ^ f_s ^ k;
  assign y_next = x;

endmodule

// File: rtl/simon_encrypt.sv
// Iterative Simon 32/64 encryption engine: one round per clock, valid/ready on both sides.
module simon_encrypt
  import simon_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_BUS_W-1:0]   key_total,
  input  logic                   key_valid,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*WORD_W-1:0]    plaintext,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WORD_W-1:0]    ciphertext,
  output logic                   busy
);

  state_t            state_r;
  logic [WORD_W-1:0] x_r;
  logic [WORD_W-1:0] y_r;
  logic [RND_W-1:0]  round_r;
  logic              out_valid_r;
  logic              busy_r;
  logic [WORD_W-1:0] key_s;
  logic [WORD_W-1:0] x_next_s;
  logic [WORD_W-1:0] y_next_s;
  logic              last_s;

  assign key_s  = key_total[round_r*WORD_W +: WORD_W];
  assign last_s = (round_r == RND_W'(ROUNDS - 1));

  simon_round u_round (
    .x      (x_r),
    .y      (y_r),
    .k      (key_s),
    .x_next (x_next_s),
    .y_next (y_next_s)
  );

  // Gated by rst so nothing is offered while reset is held.
  assign in_ready   = rst & key_valid & (state_r == IDLE);
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign ciphertext = {x_r, y_r};

  // Control FSM, round counter and block state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      x_r         <= {WORD_W{1'b0}};
      y_r         <= {WORD_W{1'b0}};
      round_r     <= {RND_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && key_valid) begin
            x_r     <= plaintext[2*WORD_W-1:WORD_W];
            y_r     <= plaintext[WORD_W-1:0];
            round_r <= {RND_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          x_r     <= x_next_s;
          y_r     <= y_next_s;
          round_r <= round_r + RND_W'(1);
          if (last_s) begin
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_encrypt.sv
// Directed self-checking bench for simon_encrypt using the published Simon 32/64 vector.
module tb_simon_encrypt;

  logic         clk;
  logic         rst;
  logic [511:0] key_total;
  logic         key_valid;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  ciphertext;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  simon_encrypt dut (
    .clk        (clk),
    .rst        (rst),
    .key_total  (key_total),
    .key_valid  (key_valid),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rl(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] rr(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  // Simon 32/64 key expansion from the four master key words (k0 = least significant).
  function automatic logic [511:0] expand(input logic [63:0] key);
    logic [0:61]  z;
    logic [15:0]  k [32];
    logic [15:0]  t;
    logic [511:0] bus;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rr(k[i-1], 3) ^ k[i-3];
      t = t ^ rr(t, 1);
      k[i] = ~k[i-4] ^ t ^ {15'd0, z[(i-4) % 62]} ^ 16'h0003;
    end
    for (int i = 0; i < 32; i++) bus[16*i +: 16] = k[i];
    return bus;
  endfunction

  function automatic logic [31:0] ref_enc(input logic [31:0] pt, input logic [511:0] keys);
    logic [15:0] a, b, t;
    a = pt[31:16];
    b = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = a;
      a = b ^ ((rl(a, 1) & rl(a, 8)) ^ rl(a, 2)) ^ keys[16*i +: 16];
      b = t;
    end
    return {a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ticks until out_valid or the bound expires; n counts edges taken.
  task automatic wait_out(input int start, output int n);
    n = start;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  logic [31:0] pt2, pt_r, held;
  logic [511:0] keys;
  int n, last_acc, acc;

  initial begin
    keys      = expand(64'h1918_1110_0908_0100);
    rst       = 1'b0;
    key_total = keys;
    key_valid = 1'b1;
    in_valid  = 1'b0;
    plaintext = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ct", ciphertext, 32'h0);
    chk("model_vector", ref_enc(32'h6565_6877, keys), 32'hc69b_e9bb);
    rst = 1'b1;
    #1;

    // Standard vector with first-round and latency checks.
    in_valid  = 1'b1;
    plaintext = 32'h6565_6877;
    #1;
    chk("std_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("std_busy", {31'd0, busy}, 32'd1);
    chk("std_loaded", ciphertext, 32'h6565_6877);
    tick();
    chk("first_round", ciphertext, 32'hbca2_6565);
    wait_out(1, n);
    chk("std_latency", n, 32'd32);
    chk("std_ct", ciphertext, 32'hc69b_e9bb);
    chk("std_busy_done", {31'd0, busy}, 32'd0);

    // Backpressure in DONE with a competing input offered.
    held      = ciphertext;
    pt2       = 32'hdead_beef;
    plaintext = pt2;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_ct_stable", ciphertext, held);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp2_busy", {31'd0, busy}, 32'd1);
    wait_out(0, n);
    chk("bp2_latency", n, 32'd32);
    chk("bp2_ct", ciphertext, ref_enc(pt2, keys));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Key gating: input held while the schedule is not valid.
    key_valid = 1'b0;
    in_valid  = 1'b1;
    plaintext = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("kg_in_ready", {31'd0, in_ready}, 32'd0);
      chk("kg_busy", {31'd0, busy}, 32'd0);
    end
    key_valid = 1'b1;
    #1;
    chk("kg_ready_up", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("kg_busy_up", {31'd0, busy}, 32'd1);
    wait_out(0, n);
    chk("kg_latency", n, 32'd32);
    chk("kg_ct", ciphertext, ref_enc(32'h1234_5678, keys));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a block.
    in_valid  = 1'b1;
    plaintext = 32'h6565_6877;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ct", ciphertext, 32'h0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(0, n);
    chk("post_rst_latency", n, 32'd32);
    chk("post_rst_ct", ciphertext, 32'hc69b_e9bb);
    out_ready = 1'b1;
    tick();

    // Back-to-back random blocks with the consumer always ready.
    last_acc = 0;
    for (int b = 0; b < 4; b++) begin
      pt_r      = $urandom;
      plaintext = pt_r;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
        tick();
        n++;
      end
      chk("b2b_ready_seen", {31'd0, in_ready}, 32'd1);
      acc = cyc;
      tick();
      in_valid = 1'b0;
      if (b > 0) chk("b2b_spacing", acc - last_acc, 32'd34);
      last_acc = acc;
      wait_out(0, n);
      chk("b2b_latency", n, 32'd32);
      chk("b2b_ct", ciphertext, ref_enc(pt_r, keys));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_encrypt.md
Name: simon_encrypt

Overview:
- Iterative Simon 32/64 encryption engine: 32-bit block, 16-bit words, 32 rounds, one round per clock.
- Sits directly downstream of the key-schedule block and consumes its 512-bit packed round-key bus, `key_total`.
- Round i uses `key_total[16*i+15:16*i]`.
- Valid/ready handshakes on both the plaintext input and the ciphertext output.

Parameters:
- WORD_W, 16, word width in bits (block = 2*WORD_W).
- ROUNDS, 32, number of rounds; also the number of keys on `key_total`.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-low.
- key_total  in  512  packed round keys; key i in bits [16i+15:16i].
- key_valid  in  1  high when `key_total` holds the full settled schedule.
- in_valid  in  1  plaintext offered.
- in_ready  out  1  engine can accept plaintext.
- plaintext  in  32  block; x = [31:16], y = [15:0].
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer takes ciphertext.
- ciphertext  out  32  result {x,y}.
- busy  out  1  high while rounds are executing.

Behaviour:
- Reset is async on rst=0.
  - State = IDLE; x, y, round counter = 0.
  - in_ready = 0, out_valid = 0, busy = 0, ciphertext = 0.
  - Reset mid-operation aborts the block silently; no partial output is ever presented.
- Round function (per round i):
  - f(x) = (rotl1(x) & rotl8(x)) ^ rotl2(x).
  - x' = y ^ f(x) ^ k_i; y' = x.
  - All rotates are modulo WORD_W; all ops are bitwise XOR/AND, no carries.
- FSM states: IDLE, RUN, DONE (one-hot or encoded, registered).
- IDLE:
  - in_ready = key_valid (combinational from state and key_valid).
  - Accept on an edge with in_valid & in_ready: x <= plaintext[31:16], y <= plaintext[15:0], round <= 0, go to RUN.
  - in_valid while key_valid=0 is ignored; the input is held by the producer.
- RUN:
  - busy = 1, in_ready = 0.
  - Each edge applies one round with key[round], then round <= round+1 (5-bit).
  - On the edge where round == ROUNDS-1, apply the last round and go to DONE; the counter wraps to 0.
- DONE:
  - out_valid = 1; ciphertext = {x,y} held stable.
  - On out_valid & out_ready, go to IDLE; out_valid drops the next cycle.
  - No new input is accepted in DONE (no overlap). in_ready returns one cycle after the output handshake.
- Latency: out_valid rises exactly ROUNDS = 32 cycles after the accepting edge. Throughput is one block per 34 cycles minimum (accept, 32 rounds, output handshake).
- Ciphertext output is registered and driven from the x/y registers.
  - In RUN it shows intermediate state but is qualified only by out_valid.
  - After reset it is 0.
- `key_total` and `key_valid` are sampled live each RUN cycle and must stay stable from accept to DONE.
  - If key_valid falls during RUN, the engine does not stall. The result is undefined, but the FSM still completes normally.
- Simultaneous reset and handshake: reset wins.

Decomposition:
- Package simon_pkg holds:
  - WORD_W, ROUNDS, KEY_BUS_W = ROUNDS*WORD_W.
  - Enum state_t {IDLE, RUN, DONE}.
  - A function for the rotate-left.
- One sub-module, simon_round: combinational, ports x, y, k → x_next, y_next; instantiated once and reused each cycle.
- The top level holds the FSM, the counter, the key mux (select key[round] from `key_total`), and the x/y registers.

Test Plan:
- Standard vector: key_total built from key 1918_1110_0908_0100, key_valid=1, plaintext 6565_6877 → out_valid exactly 32 cycles after accept, ciphertext c69b_e9bb.
- First-round check: same key and plaintext → after the first RUN edge, {x,y} = bca2_6565 (k0 = 0100, f = d5d5).
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid and ciphertext stay stable, in_ready stays 0; release → IDLE next cycle, a second block is accepted, and the second result is correct.
- Key gating: key_valid=0 with in_valid=1 for 5 cycles → in_ready=0, no accept; raise key_valid → accept on the next edge, normal 32-cycle latency.
- Reset mid-run: assert rst=0 at round 15 → outputs immediately 0, FSM IDLE; release, re-run the standard vector → c69b_e9bb.
- Back-to-back: 4 random blocks with out_ready tied 1 → each result matches a reference model, and accepts are spaced 34 cycles apart.
